// File: rtl/seg7_scan.sv
// Multiplexed 4-digit common-anode 7-segment scanner with per-frame shadow latching,
// anti-ghosting blank interval, leading-zero suppression and selectable output polarity.
module seg7_scan #(
  parameter int unsigned DIG_PERIOD  = 50000,
  parameter int unsigned BLANK       = 64,
  parameter int unsigned LZ_SUPPRESS = 1,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned      CNT_W    = $clog2(DIG_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_PERIOD - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);
  localparam logic             LZ       = (LZ_SUPPRESS != 0);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0][3:0]  sh;
  logic             sh_dp;

  logic             last;
  logic             in_blank;
  logic             lz_hit;
  logic [3:0]       digit;
  logic [6:0]       seg_dec;
  logic [3:0]       an_h;
  logic [6:0]       seg_h;
  logic             dp_h;

  // Active-high view of the next output word, derived from the current slot and shadow digits
  always_comb begin
    last     = (cnt == CNT_LAST);
    in_blank = (32'(cnt) < BLANK);
    digit    = sh[idx];
    lz_hit   = LZ && (idx == 2'd2) && (sh[2] == 4'd0) &&
               ((sh[3] == 4'd12) || (sh[3] == 4'd13) || (sh[3] == 4'd15));
    an_h     = 4'h0;
    seg_h    = 7'h00;
    dp_h     = 1'b0;

    case (digit)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h6F;
      4'd10:   seg_dec = 7'h77;
      4'd11:   seg_dec = 7'h7C;
      4'd13:   seg_dec = 7'h40;
      4'd14:   seg_dec = 7'h79;
      default: seg_dec = 7'h00;
    endcase

    if (!in_blank) begin
      an_h  = 4'b0001 << idx;
      seg_h = lz_hit ? 7'h00 : seg_dec;
      dp_h  = (idx == 2'd1) && sh_dp && (sh[0] != 4'hF);
    end
  end

  // Slot counter, digit index, frame shadow and registered polarity-adjusted outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= 2'd3;
      sh         <= {4{4'hF}};
      sh_dp      <= 1'b0;
      frame_tick <= 1'b0;
      an         <= {4{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
    end else begin
      cnt        <= last ? '0 : cnt + CNT_W'(1);
      frame_tick <= last && (idx == 2'd0);
      if (last) begin
        idx <= idx - 2'd1;
        if (idx == 2'd0) begin
          sh    <= {d3, d2, d1, d0};
          sh_dp <= dp_en;
        end
      end
      an  <= an_h ^ {4{INV}};
      seg <= seg_h ^ {7{INV}};
      dp  <= dp_h ^ INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (active-low and active-high) compared each cycle
// against a frame/slot arithmetic model of the display.
module tb_seg7_scan;

  localparam int unsigned P     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned FRAME = 4 * P;

  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h00, 7'h40, 7'h79, 7'h00};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d3 = 4'hF, d2 = 4'hF, d1 = 4'hF, d0 = 4'hF;
  logic       dp_en = 1'b0;
  logic [3:0] an_l, an_h;
  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h, ft_l, ft_h;

  int checks = 0;
  int errors = 0;

  // model state
  int         k;
  logic [3:0] msh [4];
  logic       mdp;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_ft, e_blank;
  int         e_slot, e_pos;

  seg7_scan #(.DIG_PERIOD(P), .BLANK(B), .LZ_SUPPRESS(1), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_en(dp_en),
    .an(an_l), .seg(seg_l), .dp(dp_l), .frame_tick(ft_l));

  seg7_scan #(.DIG_PERIOD(P), .BLANK(B), .LZ_SUPPRESS(1), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_en(dp_en),
    .an(an_h), .seg(seg_h), .dp(dp_h), .frame_tick(ft_h));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) msh[i] = 4'hF;
    mdp = 1'b0;
  endtask

  // One clock: outputs after edge k show the display state of cycle k-1 (slot/position arithmetic).
  task automatic step();
    logic [6:0] sg;
    @(posedge clk);
    #1;
    k++;
    e_pos   = (k - 1) % FRAME;
    e_slot  = 3 - e_pos / P;
    e_blank = ((e_pos % P) < B);
    sg = LUT[msh[e_slot]];
    if (e_slot == 2 && msh[2] == 4'd0 && (msh[3] == 4'd12 || msh[3] == 4'd13 || msh[3] == 4'd15))
      sg = 7'h00;
    e_an  = e_blank ? 4'h0 : 4'(1 << e_slot);
    e_seg = e_blank ? 7'h00 : sg;
    e_dp  = !e_blank && e_slot == 1 && mdp && msh[0] != 4'hF;
    e_ft  = (k % FRAME == 0);
    if (e_ft) begin
      msh[3] = d3; msh[2] = d2; msh[1] = d1; msh[0] = d0;
      mdp = dp_en;
    end
  endtask

  function automatic logic [12:0] exp_low();
    return {~e_an, ~e_seg, ~e_dp, e_ft};
  endfunction

  function automatic logic [12:0] obs_low();
    return {an_l, e_blank ? 7'h7F : seg_l, dp_l, ft_l};
  endfunction

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                            input logic [3:0] a0, input logic dpe);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_en = dpe;
  endtask

  task automatic align_frame();
    step();
    for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_digits(4'd13, 4'd2, 4'd5, 4'd3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({an_l, seg_l, dp_l, ft_l} !== 13'b1111_1111111_1_0) begin
        errors++;
        $display("FAIL reset_low cyc=%0d got %h exp %h", i, {an_l, seg_l, dp_l, ft_l}, 13'h1FFE);
      end
      checks++;
      if ({an_h, seg_h, dp_h, ft_h} !== 13'h0) begin
        errors++;
        $display("FAIL reset_high cyc=%0d got %h exp 0", i, {an_h, seg_h, dp_h, ft_h});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    logic [6:0] slot_seg [4] = '{7'h30, 7'h12, 7'h24, 7'h3F};
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (obs_low() !== exp_low()) begin
        errors++;
        $display("FAIL scan k=%0d got %h exp %h", k, obs_low(), exp_low());
      end
      if (k > FRAME && !e_blank) begin
        checks++;
        if (seg_l !== slot_seg[e_slot]) begin
          errors++;
          $display("FAIL scan_seg slot=%0d got %h exp %h", e_slot, seg_l, slot_seg[e_slot]);
        end
      end
    end
  endtask

  task automatic test_lz();
    set_digits(4'd12, 4'd0, 4'd7, 4'd15, 1'b1);
    align_frame();
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (obs_low() !== exp_low()) begin
        errors++;
        $display("FAIL lz k=%0d got %h exp %h", k, obs_low(), exp_low());
      end
      if (!e_blank && e_slot == 2) begin
        checks++;
        if ({an_l, seg_l} !== {4'b1011, 7'h7F}) begin
          errors++;
          $display("FAIL lz_slot2 got %h exp %h", {an_l, seg_l}, {4'b1011, 7'h7F});
        end
      end
      if (!e_blank && e_slot == 1) begin
        checks++;
        if ({seg_l, dp_l} !== {7'h78, 1'b1}) begin
          errors++;
          $display("FAIL lz_slot1 got %h exp %h", {seg_l, dp_l}, {7'h78, 1'b1});
        end
      end
    end
  endtask

  task automatic test_shadow();
    set_digits(4'd13, 4'd2, 4'd5, 4'd3, 1'b1);
    align_frame();
    for (int i = 0; i < 3 * FRAME + 12; i++) begin
      if (i == 12) set_digits(4'd12, 4'd1, 4'd1, 4'd1, 1'b0);
      step();
      checks++;
      if (obs_low() !== exp_low()) begin
        errors++;
        $display("FAIL shadow k=%0d got %h exp %h", k, obs_low(), exp_low());
      end
      if (i >= 12 && i < FRAME && !e_blank && e_slot < 2) begin
        checks++;
        if (seg_l !== ((e_slot == 1) ? 7'h12 : 7'h30)) begin
          errors++;
          $display("FAIL shadow_hold slot=%0d got %h exp %h", e_slot, seg_l,
                   (e_slot == 1) ? 7'h12 : 7'h30);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        d3 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(12, 15)) : 4'($urandom);
        d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        d1 = 4'($urandom);
        d0 = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        dp_en = 1'($urandom);
      end
      step();
      checks++;
      if (obs_low() !== exp_low()) begin
        errors++;
        $display("FAIL random k=%0d got %h exp %h", k, obs_low(), exp_low());
      end
    end
  endtask

  task automatic test_async_reset();
    int first = 0;
    set_digits(4'd13, 4'd2, 4'd5, 4'd3, 1'b1);
    for (int i = 0; i < FRAME && (k % FRAME) != 20; i++) step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({an_l, seg_l, dp_l, ft_l} !== 13'h1FFE) begin
      errors++;
      $display("FAIL async_low got %h exp %h", {an_l, seg_l, dp_l, ft_l}, 13'h1FFE);
    end
    checks++;
    if ({an_h, seg_h, dp_h, ft_h} !== 13'h0) begin
      errors++;
      $display("FAIL async_high got %h exp 0", {an_h, seg_h, dp_h, ft_h});
    end
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 1; i <= FRAME + 8; i++) begin
      step();
      if (ft_l && first == 0) first = i;
      checks++;
      if (obs_low() !== exp_low()) begin
        errors++;
        $display("FAIL async_run k=%0d got %h exp %h", k, obs_low(), exp_low());
      end
    end
    checks++;
    if (first != 32) begin
      errors++;
      $display("FAIL async_first_tick got %0d exp 32", first);
    end
  endtask

  task automatic test_polarity();
    @(negedge clk);
    rst = 1'b0;
    set_digits(4'd13, 4'd2, 4'd5, 4'd3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({an_h, e_blank ? 7'h00 : seg_h, dp_h, ft_h} !== {e_an, e_seg, e_dp, e_ft}) begin
        errors++;
        $display("FAIL polarity k=%0d got %h exp %h", k,
                 {an_h, e_blank ? 7'h00 : seg_h, dp_h, ft_h}, {e_an, e_seg, e_dp, e_ft});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_lz();
    test_shadow();
    test_random();
    test_async_reset();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
